// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the block RAM arbiter: two req/gnt access ports with read return.
// master = requesters, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin req/gnt arbiter sharing one write-port / registered-read-port block RAM
// between the monitor (port 0) and the cpu (port 1), with a burst limit under contention.
module ram_port_arbiter #(
  parameter int AW         = 9,
  parameter int DW         = 8,
  parameter int MAX_BURST  = 16,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  ram_port_arbiter_if.slave bus,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          owner,
  output logic          busy
);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_own, req_oth;
  logic          gnt0, gnt1;
  logic [1:0]    vld_p1;

  function automatic state_t own_state(input logic p);
    return p ? OWN1 : OWN0;
  endfunction

  // Stage p0: ownership state, burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= ~FIRST_PRIO;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    req_own      = last_owner_q ? bus.req1 : bus.req0;
    req_oth      = last_owner_q ? bus.req0 : bus.req1;
    gnt0         = (state_q == OWN0) && bus.req0;
    gnt1         = (state_q == OWN1) && bus.req1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req0 && bus.req1) begin
          last_owner_d = ~last_owner_q;
          state_d      = own_state(~last_owner_q);
        end else if (bus.req0 || bus.req1) begin
          last_owner_d = bus.req1;
          state_d      = own_state(bus.req1);
        end
      end
      OWN0, OWN1: begin
        if (!req_own) begin
          cnt_d = '0;
          if (req_oth) begin
            last_owner_d = ~last_owner_q;
            state_d      = own_state(~last_owner_q);
          end else begin
            state_d = IDLE;
          end
        end else if (req_oth) begin
          // Burst limit reached: hand over with no idle gap
          if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            last_owner_d = ~last_owner_q;
            state_d      = own_state(~last_owner_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // RAM is always steered to the current/last owner; only ram_we qualifies the access
  assign ram_waddr = last_owner_q ? bus.addr1 : bus.addr0;
  assign ram_raddr = ram_waddr;
  assign ram_din   = last_owner_q ? bus.wdata1 : bus.wdata0;
  assign ram_we    = last_owner_q ? (gnt1 & bus.we1) : (gnt0 & bus.we0);

  // Stage p1: read-valid aligned with the RAM's registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 2'b00;
    end else begin
      vld_p1 <= {gnt1 & ~bus.we1, gnt0 & ~bus.we0};
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = vld_p1[0];
  assign bus.rvalid1 = vld_p1[1];
  assign bus.rdata0  = ram_dout;
  assign bus.rdata1  = ram_dout;
  assign owner       = last_owner_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural 512x8 RAM, directed scenarios and a randomized
// phase, all compared against a transaction-level ownership model.
module tb_ram_port_arbiter;
  localparam int MAXB = 16;

  logic       iCE_CLK = 1'b0;
  logic       rst     = 1'b1;
  logic       preload = 1'b0;
  logic       ram_we;
  logic [8:0] ram_waddr, ram_raddr;
  logic [7:0] ram_din, ram_dout;
  logic       owner, busy;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter_if #(.AW(9), .DW(8)) bus ();

  ram_port_arbiter #(.AW(9), .DW(8), .MAX_BURST(MAXB), .FIRST_PRIO(1'b0)) dut (
    .clk(iCE_CLK), .rst(rst), .bus(bus),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_din(ram_din), .ram_dout(ram_dout), .owner(owner), .busy(busy)
  );

  always #5 iCE_CLK = ~iCE_CLK;

  function automatic logic [7:0] pre_val(input int i);
    return (i == 511) ? 8'h3C : 8'(i * 37 + 5);
  endfunction

  logic [7:0] tb_mem [512];
  always @(posedge iCE_CLK) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) tb_mem[i] <= pre_val(i);
    end else if (ram_we) begin
      tb_mem[ram_waddr] <= ram_din;
    end
    ram_dout <= tb_mem[ram_raddr];
  end

  // Reference model: who holds the RAM, how many grants the holder made while contended
  logic [7:0] ref_mem [512];
  bit         m_busy;
  int         m_own, m_last, m_run;
  bit         pend_v [2];
  logic [7:0] pend_d [2];
  bit         exp_g [2];

  logic       s_gnt [2], s_rv [2];
  logic [7:0] s_rd [2];
  logic       s_busy, s_we;
  logic [8:0] s_waddr;
  logic [7:0] s_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_last = 1; m_own = 1; m_run = 0;
    pend_v[0] = 0; pend_v[1] = 0;
    exp_g[0] = 0; exp_g[1] = 0;
  endtask

  task automatic set_port(input int n, input bit r, input bit w, input logic [8:0] a, input logic [7:0] d);
    if (n == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge
  task automatic cycle();
    bit         rq [2], wv [2];
    logic [8:0] ad [2];
    logic [7:0] wd [2];
    bit         nv [2];
    logic [7:0] nd [2];
    int         o;
    @(negedge iCE_CLK);
    rq[0] = bus.req0; rq[1] = bus.req1; wv[0] = bus.we0; wv[1] = bus.we1;
    ad[0] = bus.addr0; ad[1] = bus.addr1; wd[0] = bus.wdata0; wd[1] = bus.wdata1;
    for (int n = 0; n < 2; n++) exp_g[n] = m_busy && (m_own == n) && rq[n];
    s_gnt[0] = bus.gnt0; s_gnt[1] = bus.gnt1; s_rv[0] = bus.rvalid0; s_rv[1] = bus.rvalid1;
    s_rd[0] = bus.rdata0; s_rd[1] = bus.rdata1; s_busy = busy; s_we = ram_we;
    s_waddr = ram_waddr; s_din = ram_din;
    chk("gnt0", bus.gnt0, exp_g[0]);
    chk("gnt1", bus.gnt1, exp_g[1]);
    chk("ram_we", ram_we, exp_g[m_last] && wv[m_last]);
    chk("ram_waddr", ram_waddr, ad[m_last]);
    chk("ram_raddr", ram_raddr, ad[m_last]);
    chk("ram_din", ram_din, wd[m_last]);
    chk("owner", owner, m_last);
    chk("busy", busy, m_busy);
    chk("rvalid0", bus.rvalid0, pend_v[0]);
    chk("rvalid1", bus.rvalid1, pend_v[1]);
    if (pend_v[0]) chk("rdata0", bus.rdata0, pend_d[0]);
    if (pend_v[1]) chk("rdata1", bus.rdata1, pend_d[1]);
    @(posedge iCE_CLK);
    for (int n = 0; n < 2; n++) begin
      nv[n] = exp_g[n] && !wv[n];
      nd[n] = ref_mem[ad[n]];
    end
    for (int n = 0; n < 2; n++) if (exp_g[n] && wv[n]) ref_mem[ad[n]] = wd[n];
    pend_v = nv; pend_d = nd;
    if (!m_busy) begin
      if (rq[0] || rq[1]) begin
        m_own  = (rq[0] && rq[1]) ? 1 - m_last : (rq[0] ? 0 : 1);
        m_last = m_own; m_busy = 1; m_run = 0;
      end
    end else begin
      o = 1 - m_own;
      if (!rq[m_own]) begin
        if (rq[o]) begin m_own = o; m_last = o; m_run = 0; end
        else m_busy = 0;
      end else if (rq[o]) begin
        m_run++;
        if (m_run == MAXB) begin m_own = o; m_last = o; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  initial begin
    int g0_before, first1, last0, cnt_g, cnt_rv, first_g, last_g, idx;
    bit seen1;
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    for (int i = 0; i < 512; i++) ref_mem[i] = pre_val(i);
    m_reset();
    preload = 1'b1;
    @(posedge iCE_CLK); #1;
    preload = 1'b0;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    @(posedge iCE_CLK); #1;
    rst = 1'b0;

    // 1: single write, one-cycle arbitration latency
    set_port(0, 1, 1, 9'h010, 8'hA5);
    cycle();
    chk("t1_latency_gnt0", s_gnt[0], 0);
    cycle();
    chk("t1_gnt0", s_gnt[0], 1);
    chk("t1_we", s_we, 1);
    chk("t1_waddr", s_waddr, 9'h010);
    chk("t1_din", s_din, 8'hA5);
    set_port(0, 0, 0, '0, '0);
    cycle();

    // 2: port 1 reads the preloaded top word
    set_port(1, 1, 0, 9'h1FF, 8'h00);
    cycle();
    cycle();
    chk("t2_gnt1", s_gnt[1], 1);
    set_port(1, 0, 0, '0, '0);
    cycle();
    chk("t2_rvalid1", s_rv[1], 1);
    chk("t2_rdata1", s_rd[1], 8'h3C);
    chk("t2_rvalid0", s_rv[0], 0);
    cycle();

    // 3: simultaneous requests after reset, burst limit handover
    rst = 1'b1; m_reset();
    @(posedge iCE_CLK); #1;
    rst = 1'b0;
    set_port(0, 1, 0, 9'($urandom_range(0, 511)), 8'h00);
    set_port(1, 1, 0, 9'($urandom_range(0, 511)), 8'h00);
    g0_before = 0; first1 = -1; last0 = -1; seen1 = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (s_gnt[1] && !seen1) begin seen1 = 1; first1 = c; end
      if (s_gnt[0] && !seen1) begin g0_before++; last0 = c; end
      if (exp_g[0]) set_port(0, 1, 0, 9'($urandom_range(0, 511)), 8'h00);
      if (exp_g[1]) set_port(1, 1, 0, 9'($urandom_range(0, 511)), 8'h00);
    end
    chk("t3_gnt0_burst", g0_before, MAXB);
    chk("t3_handover_gap", first1, last0 + 1);
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    cycle(); cycle();

    // 4: sole requester streams 100 reads without gaps
    idx = 0; cnt_g = 0; cnt_rv = 0; first_g = -1; last_g = -1;
    for (int c = 0; c < 110 && idx < 100; c++) begin
      set_port(1, 1, 0, 9'(idx), 8'h00);
      cycle();
      if (s_gnt[1]) begin cnt_g++; last_g = c; if (first_g < 0) first_g = c; end
      if (s_rv[1]) cnt_rv++;
      if (exp_g[1]) idx++;
    end
    set_port(1, 0, 0, '0, '0);
    for (int c = 0; c < 2; c++) begin
      cycle();
      if (s_rv[1]) cnt_rv++;
    end
    chk("t4_gnt1_count", cnt_g, 100);
    chk("t4_gnt1_span", last_g - first_g, 99);
    chk("t4_rvalid1_count", cnt_rv, 100);

    // 5: owner drops while the other waits, then both go idle
    set_port(0, 1, 1, 9'h055, 8'h77);
    cycle();
    set_port(1, 1, 0, 9'h055, 8'h00);
    cycle(); cycle();
    set_port(0, 0, 0, '0, '0);
    cycle();
    cycle();
    chk("t5_gnt1_after_drop", s_gnt[1], 1);
    set_port(1, 0, 0, '0, '0);
    cycle(); cycle();
    chk("t5_busy_idle", s_busy, 0);

    // 6: asynchronous reset in the middle of a read burst
    set_port(1, 1, 0, 9'($urandom_range(0, 511)), 8'h00);
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (exp_g[1]) set_port(1, 1, 0, 9'($urandom_range(0, 511)), 8'h00);
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_gnt0", bus.gnt0, 0);
    chk("t6_gnt1", bus.gnt1, 0);
    chk("t6_rvalid0", bus.rvalid0, 0);
    chk("t6_rvalid1", bus.rvalid1, 0);
    chk("t6_ram_we", ram_we, 0);
    chk("t6_busy", busy, 0);
    m_reset();
    @(posedge iCE_CLK); #1;
    rst = 1'b0;
    cycle();
    chk("t6_latency_gnt1", s_gnt[1], 0);
    cycle();
    chk("t6_gnt1", s_gnt[1], 1);
    set_port(1, 0, 0, '0, '0);
    cycle();

    // Randomized traffic from both requesters
    for (int c = 0; c < 3000; c++) begin
      bit rq_now [2];
      rq_now[0] = bus.req0; rq_now[1] = bus.req1;
      for (int n = 0; n < 2; n++) begin
        if (rq_now[n] && exp_g[n]) begin
          if ($urandom_range(0, 9) < 8)
            set_port(n, 1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 8'($urandom));
          else
            set_port(n, 0, 0, '0, '0);
        end else if (rq_now[n]) begin
          if ($urandom_range(0, 99) < 3) set_port(n, 0, 0, '0, '0);
        end else if ($urandom_range(0, 9) < 4) begin
          set_port(n, 1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 8'($urandom));
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
